// File: rtl/sum_accum_pkg.sv
// Shared constants and helpers for the sum_accum group accumulator.
package sum_accum_pkg;

  localparam int SUM_W_DEFAULT = 5;
  localparam int ACC_W_DEFAULT = 12;
  localparam int COUNT_DEFAULT = 4;

  // Largest value an acc_w-bit unsigned total can hold.
  function automatic longint unsigned acc_max(input int acc_w);
    return (longint'(1) << acc_w) - 1;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add of one unsigned sample into a running total.
module sat_add
  import sum_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SUM_W = SUM_W_DEFAULT
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             sat_in,
  output logic [ACC_W-1:0] sum,
  output logic             sat_out
);

  localparam logic [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));

  logic [ACC_W:0] wide;
  logic           clip;

  // acc <= MAX and in_sum < 2^ACC_W, so overflow shows up only in the carry bit.
  always_comb begin
    wide    = {1'b0, acc} + (ACC_W + 1)'(in_sum);
    clip    = wide[ACC_W];
    sum     = clip ? MAX : wide[ACC_W-1:0];
    sat_out = sat_in | clip;
  end

endmodule

// File: rtl/sum_accum.sv
// Accumulates groups of COUNT unsigned samples into a saturating total,
// with a one-deep result register decoupling the running group from the consumer.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int COUNT = COUNT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int              CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [ACC_W-1:0] acc_reg;
  logic             sat_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [ACC_W-1:0] acc_next;
  logic             sat_next;
  logic             last;
  logic             accept;
  logic             pop;

  sat_add #(
    .ACC_W(ACC_W),
    .SUM_W(SUM_W)
  ) u_sat_add (
    .acc    (acc_reg),
    .in_sum (in_sum),
    .sat_in (sat_reg),
    .sum    (acc_next),
    .sat_out(sat_next)
  );

  // Stall only when a completing sample would overwrite an unconsumed result.
  always_comb begin
    last     = (cnt_reg == LAST);
    in_ready = !clear && !(last && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    pop      = out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (clear) begin
        acc_reg <= '0;
        sat_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (accept) begin
        if (last) begin
          out_acc <= acc_next;
          out_sat <= sat_next;
          acc_reg <= '0;
          sat_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          acc_reg <= acc_next;
          sat_reg <= sat_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      if (accept && last) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: three parameterisations share one stimulus stream,
// each scored every cycle against a group-sum model plus directed literal checks.
module tb_sum_accum;

  localparam int NI = 3;
  localparam int ACCW[NI] = '{12, 6, 12};
  localparam int CNTS[NI] = '{4, 4, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_sum = '0;
  logic       out_ready = 1'b1;

  logic        ir   [NI];
  logic        ov   [NI];
  logic [11:0] oacc [NI];
  logic        osat [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int AW = ACCW[gi];
    localparam int C  = CNTS[gi];
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic          ir_w, ov_w, sat_w;
    logic [AW-1:0] acc_w;

    sum_accum #(.SUM_W(5), .ACC_W(AW), .COUNT(C)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (ir_w),
      .in_sum   (in_sum),
      .out_valid(ov_w),
      .out_ready(out_ready),
      .out_acc  (acc_w),
      .out_sat  (sat_w)
    );

    assign ir[gi]   = ir_w;
    assign ov[gi]   = ov_w;
    assign oacc[gi] = 12'(acc_w);
    assign osat[gi] = sat_w;

    // Model: unclamped running group sum; clamp and flag only when the group closes.
    longint g_sum = 0;
    int     g_cnt = 0;
    bit     m_ov = 0;
    longint m_oacc = 0;
    bit     m_osat = 0;

    function automatic bit exp_ready();
      return !clear && !(g_cnt == C - 1 && m_ov && !out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        g_sum = 0; g_cnt = 0; m_ov = 0; m_oacc = 0; m_osat = 0;
      end else begin
        bit take, pop;
        take = in_valid && exp_ready();
        pop  = m_ov && out_ready;
        if (clear) begin
          g_sum = 0; g_cnt = 0;
        end else if (take) begin
          g_sum += longint'(in_sum);
          g_cnt++;
        end
        if (take && g_cnt == C) begin
          m_oacc = (g_sum > MAXV) ? MAXV : g_sum;
          m_osat = (g_sum > MAXV);
          m_ov   = 1;
          g_sum  = 0;
          g_cnt  = 0;
        end else if (pop) begin
          m_ov = 0;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("i%0d in_ready", gi), longint'(ir_w), longint'(exp_ready()));
      check($sformatf("i%0d out_valid", gi), longint'(ov_w), longint'(m_ov));
      check($sformatf("i%0d out_acc", gi), longint'(acc_w), m_oacc);
      check($sformatf("i%0d out_sat", gi), longint'(sat_w), longint'(m_osat));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_sum   = 5'(v);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input int i, input string tag, input int v, input int a, input int s);
    check({tag, " ov"}, longint'(ov[i]), longint'(v));
    check({tag, " acc"}, longint'(oacc[i]), longint'(a));
    check({tag, " sat"}, longint'(osat[i]), longint'(s));
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    expect_out(0, "reset", 0, 0, 0);
    check("reset in_ready", longint'(ir[0]), 1);

    // Basic group 0+2+16+31 = 49
    feed(0); feed(2); feed(16); feed(31);
    expect_out(0, "basic", 1, 49, 0);
    cyc();
    expect_out(0, "basic pop", 0, 49, 0);

    // Saturation in the 6-bit instance, then cleared for the next group
    feed(31); feed(31); feed(31); feed(31);
    expect_out(1, "sat6", 1, 63, 1);
    expect_out(0, "nosat12", 1, 124, 0);
    feed(1); feed(1); feed(1); feed(1);
    expect_out(1, "sat6 next", 1, 4, 0);
    cyc();

    // Back-pressure: A=4 held, B's last sample stalls until A pops
    out_ready = 1'b0;
    feed(1); feed(1); feed(1); feed(1);
    expect_out(0, "bp A", 1, 4, 0);
    feed(2); feed(2); feed(2);
    in_valid = 1'b1;
    in_sum   = 5'd2;
    #1;
    check("bp stall in_ready", longint'(ir[0]), 0);
    cyc();
    expect_out(0, "bp hold", 1, 4, 0);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", longint'(ir[0]), 1);
    cyc();
    in_valid = 1'b0;
    expect_out(0, "bp B", 1, 8, 0);
    cyc();

    // Clear discards a partial group and blocks the sample that cycle
    feed(5); feed(7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 5'd9;
    #1;
    check("clear in_ready", longint'(ir[0]), 0);
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    feed(1); feed(1); feed(1); feed(1);
    expect_out(0, "after clear", 1, 4, 0);

    // Asynchronous reset mid-group with a pending result
    feed(3); feed(3);
    #2;
    rst = 1'b1;
    #1;
    expect_out(0, "async rst", 0, 0, 0);
    expect_out(1, "async rst i1", 0, 0, 0);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    feed(3); feed(3); feed(3); feed(3);
    expect_out(0, "post rst", 1, 12, 0);
    cyc();

    // COUNT=1: every accept is a group
    feed(15);
    expect_out(2, "c1 first", 1, 15, 0);
    check("c1 in_ready", longint'(ir[2]), 1);
    feed(16);
    expect_out(2, "c1 second", 1, 16, 0);
    check("c1 in_ready 2", longint'(ir[2]), 1);
    cyc();

    // Randomised traffic scored by the models
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = 5'($urandom);
      clear     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
Name: sum_accum

Overview:
Downstream consumer of the adder4 sum stream. Accepts 5-bit sums over a valid/ready handshake and accumulates each group of COUNT samples into a saturating ACC_W-bit total. Emits the group total with a sticky saturation flag over a second valid/ready handshake. Output is double-buffered against the running accumulator, so input only stalls when a second group completes while the previous result is still unconsumed.

Parameters:
SUM_W, 5, width of incoming sum (equals adder4 sum width)
ACC_W, 12, accumulator/result width; must be >= SUM_W
COUNT, 4, samples per group; must be >= 1
CNT_W, $clog2(COUNT) (min 1), sample counter width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous discard of the partial group
in_valid  in  1  in_sum valid
in_ready  out  1  block accepts in_sum this cycle
in_sum  in  SUM_W  unsigned sum from adder4
out_valid  out  1  out_acc/out_sat hold a completed group
out_ready  in  1  downstream accepts result
out_acc  out  ACC_W  saturated group total
out_sat  out  1  group total clipped at 2^ACC_W-1

Behaviour:
- Reset (async, rst=1): acc=0, cnt=0, sat=0, out_valid=0, out_acc=0, out_sat=0. in_ready=1 once rst deasserts.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready.
- Saturating add: nxt = acc + in_sum, computed at ACC_W+1 bits. If nxt > 2^ACC_W-1, the result clamps to 2^ACC_W-1 and nxt_sat=1. nxt_sat = sat | clip.
- Accept with cnt < COUNT-1: acc<=nxt, sat<=nxt_sat, cnt<=cnt+1.
- Accept with cnt == COUNT-1 (group complete):
  - out_acc<=nxt, out_sat<=nxt_sat, out_valid<=1.
  - acc<=0, sat<=0, cnt<=0.
  - Latency: result is visible the cycle after the final accept.
- COUNT=1: every accept completes a group.
- in_ready = !clear && !(cnt==COUNT-1 && out_valid && !out_ready).
  - Combinational path out_ready->in_ready is intended.
  - A pop and a completing accept in the same cycle are legal: the new result replaces the old, and out_valid stays 1.
- Pop without completion: out_valid<=0. out_acc/out_sat retain their last value.
- Output stability: while out_valid && !out_ready, out_acc/out_sat must not change.
- clear=1:
  - acc<=0, sat<=0, cnt<=0; in_ready=0, so no accept that cycle.
  - Pending output is unaffected and a pop may occur the same cycle.
- in_sum is ignored when no accept occurs. Behaviour when in_valid drops without acceptance is unconstrained (no protocol check).
- Reset mid-group or with pending output: all state is discarded immediately, nothing is emitted.

Decomposition:
- Package sum_accum_pkg:
  - SUM_W_DEFAULT=5 (shared with adder4 width)
  - ACC_MAX function (2^ACC_W-1)
- Sub-module sat_add: combinational (acc, in_sum, sat_in) -> (sum, sat_out), parameterised ACC_W/SUM_W.
- Everything else (counter, output register, ready logic) stays in sum_accum.

Test Plan:
- Reset then 4 accepts of 0,2,16,31 with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_acc=49, out_sat=0; pops next cycle.
- ACC_W=6 override, samples 31,31,31,31 -> out_acc=63, out_sat=1. Next group 1,1,1,1 -> out_acc=4, out_sat=0 (sat cleared per group).
- Back-pressure:
  - out_ready=0 after group A=4 (1,1,1,1); feed group B 2,2,2,2.
  - First three B samples accepted; in_ready=0 on the fourth, out_acc holds 4.
  - Raise out_ready -> A pops the same cycle B's fourth is accepted; next cycle out_acc=8, out_valid=1.
- Two samples 5,7 then clear=1 with in_valid=1 -> in_ready=0, no accept. Then 1,1,1,1 -> out_acc=4.
- rst asserted asynchronously mid-group (cnt=2) and with out_valid=1 -> all outputs 0 immediately. Next full group 3,3,3,3 -> out_acc=12.
- COUNT=1 override, stream 15,16 with out_ready=1 -> out_acc=15 then 16 on consecutive cycles, in_ready held 1.
